// File: rtl/conv_layer_window_gen_if.sv
// Bus bundle between the layer controller / external memory and the window generator.
interface conv_layer_window_gen_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ARRAY_SIZE = 6
);
  logic                             enable;
  logic [1:0]                       cmd;
  logic [ADDR_WIDTH-1:0]            base_addr;
  logic [DATA_WIDTH-1:0]            rom_data;
  logic                             rom_en;
  logic [ADDR_WIDTH-1:0]            rom_addr;
  logic [1:0]                       ack;
  logic [2:0]                       current_state;
  logic                             out_valid;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_kernel_port;

  modport master (
    output enable, cmd, base_addr, rom_data,
    input  rom_en, rom_addr, ack, current_state, out_valid, out_kernel_port
  );

  modport slave (
    input  enable, cmd, base_addr, rom_data,
    output rom_en, rom_addr, ack, current_state, out_valid, out_kernel_port
  );
endinterface

// File: rtl/conv_layer_window_gen.sv
// Caches K image rows in a ring of row buffers and streams sliding-window
// columns plus one bias beat to the conv kernel array.
module conv_layer_window_gen #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned IMAGE_WIDTH = 8,
  parameter int unsigned ARRAY_SIZE  = 6,
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] BIAS_VALUE = DATA_WIDTH'(32'h3F800000)
) (
  input  logic clk,
  input  logic rst_n,
  conv_layer_window_gen_if.slave bus
);

  localparam int unsigned K     = KERNEL_SIZE;
  localparam int unsigned W     = IMAGE_WIDTH;
  localparam int unsigned A     = ARRAY_SIZE;
  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned KW    = K * W;
  localparam int unsigned ROW_W = $clog2(K);
  localparam int unsigned COL_W = $clog2(W);
  localparam int unsigned RD_W  = $clog2(KW);

  localparam logic [1:0] CMD_PRELOAD = 2'd1;
  localparam logic [1:0] CMD_SHIFT   = 2'd2;
  localparam logic [1:0] CMD_LOAD    = 2'd3;
  localparam logic [1:0] ACK_NONE    = 2'd0;
  localparam logic [1:0] ACK_PRELOAD = 2'd1;
  localparam logic [1:0] ACK_SHIFT   = 2'd2;
  localparam logic [1:0] ACK_LOAD    = 2'd3;

  if (K < 2 || K > 7 || W < K || A != W - K + 1) begin : g_param_check
    $error("conv_layer_window_gen: inconsistent KERNEL_SIZE/IMAGE_WIDTH/ARRAY_SIZE");
  end

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_PRELOAD = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_BIAS    = 3'd5,
    ST_LOAD    = 3'd6,
    ST_IDLE    = 3'd7
  } state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic                  rd_active_q;
  logic [RD_W-1:0]       rd_cnt_q;
  logic                  cap_valid_q;
  logic [COL_W-1:0]      wr_col_q;
  logic [ROW_W-1:0]      wr_slot_q;
  logic                  wr_done_q;
  logic [ROW_W-1:0]      ring_q;
  logic [ROW_W-1:0]      row_idx_q;
  logic [ROW_W-1:0]      beat_q;
  logic [ROW_W-1:0]      sh_slot_q;
  logic [W*DW-1:0]       sr_q;
  logic [A*DW-1:0]       out_q;
  logic                  out_valid_q;
  logic [1:0]            ack_q;
  logic [DW-1:0]         rows_q [K][W];

  logic                  rom_en_c;
  logic                  rd_last_c;
  logic                  last_wr_c;
  logic [W*DW-1:0]       row_rev_c;
  logic [W*DW-1:0]       next_sr_c;

  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] r);
    return (r == ROW_W'(K - 1)) ? '0 : r + ROW_W'(1);
  endfunction

  // Reads stop the moment enable drops; in-flight data is still captured below.
  assign rom_en_c  = rd_active_q & bus.enable;
  assign rd_last_c = (state_q == ST_PRELOAD) ? (rd_cnt_q == RD_W'(KW - 1))
                                             : (rd_cnt_q == RD_W'(W - 1));
  assign last_wr_c = cap_valid_q && (wr_col_q == COL_W'(W - 1)) &&
                     ((state_q == ST_LOAD) || (wr_slot_q == ROW_W'(K - 1)));

  // Word 0 of a row sits at the MSB so shifting toward the MSB slides the window right.
  for (genvar j = 0; j < W; j++) begin : g_rev
    assign row_rev_c[j*DW +: DW] = rows_q[sh_slot_q][W-1-j];
  end

  assign next_sr_c = (beat_q == '0) ? row_rev_c : {sr_q[(W-1)*DW-1:0], DW'(0)};

  always_ff @(posedge clk) begin
    if (cap_valid_q) rows_q[wr_slot_q][wr_col_q] <= bus.rom_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      rom_addr_q  <= '0;
      rd_active_q <= 1'b0;
      rd_cnt_q    <= '0;
      cap_valid_q <= 1'b0;
      wr_col_q    <= '0;
      wr_slot_q   <= '0;
      wr_done_q   <= 1'b0;
      ring_q      <= '0;
      row_idx_q   <= '0;
      beat_q      <= '0;
      sh_slot_q   <= '0;
      sr_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= ACK_NONE;
    end else begin
      // Capture stage runs regardless of enable.
      cap_valid_q <= rom_en_c;
      if (cap_valid_q) begin
        if (wr_col_q == COL_W'(W - 1)) begin
          wr_col_q  <= '0;
          wr_slot_q <= row_inc(wr_slot_q);
        end else begin
          wr_col_q <= wr_col_q + COL_W'(1);
        end
      end
      if (last_wr_c) wr_done_q <= 1'b1;

      if (bus.enable) begin
        ack_q       <= ACK_NONE;
        out_valid_q <= 1'b0;
        out_q       <= '0;

        if (rd_active_q) begin
          rom_addr_q <= rom_addr_q + ADDR_WIDTH'(1);
          rd_cnt_q   <= rd_cnt_q + RD_W'(1);
          if (rd_last_c) rd_active_q <= 1'b0;
        end

        case (state_q)
          ST_INIT, ST_IDLE: begin
            if (bus.cmd == CMD_PRELOAD) begin
              rom_addr_q  <= bus.base_addr;
              rd_active_q <= 1'b1;
              rd_cnt_q    <= '0;
              wr_col_q    <= '0;
              wr_slot_q   <= '0;
              ring_q      <= '0;
              state_q     <= ST_PRELOAD;
            end else if (state_q == ST_IDLE && bus.cmd == CMD_SHIFT) begin
              row_idx_q <= '0;
              beat_q    <= '0;
              sh_slot_q <= ring_q;
              state_q   <= ST_SHIFT;
            end else if (state_q == ST_IDLE && bus.cmd == CMD_LOAD) begin
              rd_active_q <= 1'b1;
              rd_cnt_q    <= '0;
              wr_col_q    <= '0;
              wr_slot_q   <= ring_q;
              state_q     <= ST_LOAD;
            end
          end

          ST_PRELOAD: begin
            if (last_wr_c || wr_done_q) begin
              wr_done_q <= 1'b0;
              ack_q     <= ACK_PRELOAD;
              state_q   <= ST_IDLE;
            end
          end

          ST_LOAD: begin
            if (last_wr_c || wr_done_q) begin
              wr_done_q <= 1'b0;
              ring_q    <= row_inc(ring_q);
              ack_q     <= ACK_LOAD;
              state_q   <= ST_IDLE;
            end
          end

          ST_SHIFT: begin
            sr_q        <= next_sr_c;
            out_q       <= next_sr_c[W*DW-1 -: A*DW];
            out_valid_q <= 1'b1;
            if (beat_q == ROW_W'(K - 1)) begin
              beat_q    <= '0;
              sh_slot_q <= row_inc(sh_slot_q);
              if (row_idx_q == ROW_W'(K - 1)) begin
                row_idx_q <= '0;
                state_q   <= ST_BIAS;
              end else begin
                row_idx_q <= row_idx_q + ROW_W'(1);
              end
            end else begin
              beat_q <= beat_q + ROW_W'(1);
            end
          end

          ST_BIAS: begin
            out_q       <= {A{BIAS_VALUE}};
            out_valid_q <= 1'b1;
            ack_q       <= ACK_SHIFT;
            state_q     <= ST_IDLE;
          end

          default: state_q <= ST_INIT;
        endcase
      end
    end
  end

  assign bus.rom_en          = rom_en_c;
  assign bus.rom_addr        = rom_addr_q;
  assign bus.ack             = ack_q;
  assign bus.current_state   = state_q;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_kernel_port = out_q;

endmodule

// File: tb/tb_conv_layer_window_gen.sv
// Scoreboard bench for conv_layer_window_gen: K=3, W=8, A=6, memory word n = n.
module tb_conv_layer_window_gen;
  localparam int unsigned DW = 32;
  localparam int unsigned K  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned A  = 6;
  localparam int unsigned AW = 16;
  localparam logic [DW-1:0] BIAS = 32'h3F800000;

  typedef struct { logic [A*DW-1:0] data; int cyc; } beat_t;
  typedef struct { logic [1:0] code; int cyc; } ack_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_layer_window_gen_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARRAY_SIZE(A)) bus ();

  conv_layer_window_gen #(
    .DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .ARRAY_SIZE(A),
    .ADDR_WIDTH(AW), .BIAS_VALUE(BIAS)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic en_q = 1'b0;
  logic [A*DW-1:0] last_beat = '0;
  logic [1:0] last_ack = '0;

  beat_t beat_q[$];
  ack_t  ack_q[$];
  logic [AW-1:0] rd_q[$];

  task automatic check(input string name, input logic [A*DW-1:0] act, input logic [A*DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= bus.enable;
    if (bus.rom_en) bus.rom_data <= DW'(bus.rom_addr);
  end

  // Monitor: reads, output beats and ack pulses against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rom_en) begin
        if (rd_q.size() == 0) fail_now("unexpected_read", $sformatf("addr %0d, none expected", bus.rom_addr));
        else check("rom_addr", A*DW'(bus.rom_addr), A*DW'(rd_q.pop_front()));
      end
      if (bus.out_valid) begin
        if (en_q) begin
          if (beat_q.size() == 0) begin
            fail_now("unexpected_beat", $sformatf("data %0h, none expected", bus.out_kernel_port));
          end else begin
            beat_t b;
            b = beat_q.pop_front();
            check("beat", bus.out_kernel_port, b.data);
            if (b.cyc >= 0) check_int("beat_latency", cyc, b.cyc);
            last_beat = b.data;
          end
        end else begin
          check("frozen_out", bus.out_kernel_port, last_beat);
        end
      end else begin
        check("idle_out_zero", bus.out_kernel_port, '0);
      end
      if (bus.ack != 2'd0) begin
        if (en_q) begin
          if (ack_q.size() == 0) begin
            fail_now("unexpected_ack", $sformatf("ack %0d, none expected", bus.ack));
          end else begin
            ack_t a;
            a = ack_q.pop_front();
            check("ack_code", A*DW'(bus.ack), A*DW'(a.code));
            if (a.cyc >= 0) check_int("ack_latency", cyc, a.cyc);
            check("state_at_ack", A*DW'(bus.current_state), A*DW'(3'd7));
            last_ack = a.code;
          end
        end else begin
          check("held_ack", A*DW'(bus.ack), A*DW'(last_ack));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [AW-1:0] base);
    bus.cmd = c;
    bus.base_addr = base;
    tick();
    bus.cmd = 2'd0;
  endtask

  task automatic push_reads(input int base, input int n_words, input logic [1:0] code, input int ack_cyc);
    ack_t a;
    for (int i = 0; i < n_words; i++) rd_q.push_back(AW'(base + i));
    a.code = code;
    a.cyc  = ack_cyc;
    ack_q.push_back(a);
  endtask

  task automatic push_shift(input int b0, input int b1, input int b2, input int n, input bit timed);
    int bases[K];
    beat_t bt;
    ack_t a;
    bases[0] = b0; bases[1] = b1; bases[2] = b2;
    for (int r = 0; r < K; r++) begin
      for (int b = 0; b < K; b++) begin
        bt.data = '0;
        for (int i = 0; i < A; i++) bt.data[(A-1-i)*DW +: DW] = DW'(bases[r] + b + i);
        bt.cyc = (timed && r == 0 && b == 0) ? n + 2 : -1;
        beat_q.push_back(bt);
      end
    end
    bt.data = {A{BIAS}};
    bt.cyc  = timed ? n + K*K + 2 : -1;
    beat_q.push_back(bt);
    a.code = 2'd2;
    a.cyc  = timed ? n + K*K + 2 : -1;
    ack_q.push_back(a);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((rd_q.size() != 0 || beat_q.size() != 0 || ack_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n < budget) passed++;
    else $display("FAIL %s: %0d reads, %0d beats, %0d acks still pending after %0d cycles",
                  name, rd_q.size(), beat_q.size(), ack_q.size(), budget);
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, A*DW'(bus.current_state), '0);
    check({tag, "_rom_en"}, A*DW'(bus.rom_en), '0);
    check({tag, "_rom_addr"}, A*DW'(bus.rom_addr), '0);
    check({tag, "_ack"}, A*DW'(bus.ack), '0);
    check({tag, "_out_valid"}, A*DW'(bus.out_valid), '0);
    check({tag, "_out"}, bus.out_kernel_port, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    bus.enable = 1'b1;
    bus.cmd = 2'd0;
    bus.base_addr = '0;
    rst_n = 1'b0;
    tick();
    check_reset_outputs("in_reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_outputs("after_reset");

    // SHIFT and LOAD are not accepted in INIT.
    issue(2'd2, '0);
    tick();
    issue(2'd3, '0);
    tick();
    tick();
    check_reset_outputs("init_ignores_cmd");

    // PRELOAD from 0 with a stray LOAD while busy.
    n = cyc;
    push_reads(0, K*W, 2'd1, n + K*W + 2);
    issue(2'd1, 16'd0);
    for (int i = 0; i < 4; i++) tick();
    bus.cmd = 2'd3;
    for (int i = 0; i < 3; i++) tick();
    bus.cmd = 2'd0;
    wait_drain("preload0", 60);
    check("preload_state", A*DW'(bus.current_state), A*DW'(3'd7));
    check("preload_rom_addr", A*DW'(bus.rom_addr), A*DW'(24));

    n = cyc;
    push_shift(0, 8, 16, n, 1'b1);
    issue(2'd2, '0);
    wait_drain("shift0", 40);

    // SHIFT with a 3-cycle stall after the 4th beat.
    n = cyc;
    push_shift(0, 8, 16, n, 1'b0);
    issue(2'd2, '0);
    for (int i = 0; i < 4; i++) tick();
    bus.enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_state", A*DW'(bus.current_state), A*DW'(3'd2));
    end
    bus.enable = 1'b1;
    wait_drain("shift_stall", 40);

    n = cyc;
    push_reads(24, W, 2'd3, n + W + 2);
    issue(2'd3, '0);
    wait_drain("load24", 30);
    check("load_rom_addr", A*DW'(bus.rom_addr), A*DW'(32));

    n = cyc;
    push_shift(8, 16, 24, n, 1'b1);
    issue(2'd2, '0);
    wait_drain("shift_after_load", 40);

    // Reset in the middle of a LOAD.
    n = cyc;
    push_reads(32, W, 2'd3, n + W + 2);
    issue(2'd3, '0);
    k = 0;
    while (rd_q.size() > W - 4 && k < 40) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (k >= 40) fail_now("mid_load_wait", "fewer than 4 reads observed");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_load_reset");
    rd_q.delete();
    ack_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    n = cyc;
    push_reads(40, K*W, 2'd1, n + K*W + 2);
    issue(2'd1, 16'd40);
    wait_drain("preload40", 60);

    n = cyc;
    push_shift(40, 48, 56, n, 1'b1);
    issue(2'd2, '0);
    wait_drain("shift40", 40);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
